// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared types and default timing constants for the scroll step generator
package scroll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_PRESSED,
        ST_REPEAT,
        ST_DEB_RELEASE
    } step_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_HOLD_CYCLES     = 25000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;
    localparam int          STEP_COUNT_W        = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer for an asynchronous single-bit input
module key_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/scroll_step_gen.sv
// rtl/scroll_step_gen.sv - debounced push-button step pulse generator; SCROLL_AUTO_REPEAT_EN adds hold-to-repeat
module scroll_step_gen
    import scroll_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_n,
    output logic                    step,
    output logic                    held,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef SCROLL_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    step_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             key_s;
    logic             pressed_s;

    key_sync #(.RESET_VAL(1'b1)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (key_s)
    );

    assign pressed_s = ~key_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            step       <= 1'b0;
            held       <= 1'b0;
            step_count <= '0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed_s) begin
                        state <= ST_DEB_PRESS;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!pressed_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state      <= ST_PRESSED;
                        cnt        <= '0;
                        step       <= 1'b1;
                        held       <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed_s) begin
                        state <= ST_DEB_RELEASE;
                        cnt   <= CNT_ONE;
`ifdef SCROLL_AUTO_REPEAT_EN
                    end else if (cnt == HOLD_LAST) begin
                        state      <= ST_REPEAT;
                        cnt        <= '0;
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    end else begin
                        cnt <= '0;
                    end
`endif
                end
`ifdef SCROLL_AUTO_REPEAT_EN
                ST_REPEAT: begin
                    if (!pressed_s) begin
                        state <= ST_DEB_RELEASE;
                        cnt   <= CNT_ONE;
                    end else if (cnt == REP_LAST) begin
                        cnt        <= '0;
                        step       <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                // A press seen mid-release is a glitch: stay held, restart the hold timer.
                ST_DEB_RELEASE: begin
                    if (pressed_s) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_step_gen.sv
// tb/tb_scroll_step_gen.sv - scoreboard bench for scroll_step_gen; model follows SCROLL_AUTO_REPEAT_EN
module tb_scroll_step_gen;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic       step;
    logic       held;
    logic [7:0] step_count;

    int n_cmp  = 0;
    int n_fail = 0;

    scroll_step_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .step       (step),
        .held       (held),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: accepted level flips after DEB consecutive opposite samples;
    // repeat steps fall at anchor+HOLD+k*REP, anchor being the last (re)establishment of the press.
    int          cyc = 0;
    int          exp_q[$];
    logic        m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0;
    int unsigned m_opp = 0;
    int          m_anchor = 0;
    logic [7:0]  m_tally = 8'd0;

    always @(posedge clk) begin
        logic p;
        logic fire;
        cyc++;
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_opp = 0; m_tally = 8'd0;
            m_anchor = cyc;
        end else begin
            p    = ~m_s2;
            m_s2 = m_s1;
            m_s1 = key_n;
            fire = 1'b0;
            if (p != m_lvl) begin
                m_opp++;
                if (m_opp == DEB) begin
                    m_lvl = p;
                    m_opp = 0;
                    if (p) begin
                        fire     = 1'b1;
                        m_anchor = cyc;
                    end
                end
            end else begin
                if (m_lvl && m_opp != 0) m_anchor = cyc;
                m_opp = 0;
`ifdef SCROLL_AUTO_REPEAT_EN
                if (m_lvl && cyc >= m_anchor + int'(HOLD)
                    && ((cyc - m_anchor - int'(HOLD)) % int'(REP)) == 0)
                    fire = 1'b1;
`endif
            end
            if (fire) begin
                exp_q.push_back(cyc);
                m_tally = m_tally + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (step) begin
                if (exp_q.size() == 0) chk("step_extra", 1, 0);
                else chk("step_edge", cyc, exp_q.pop_front());
            end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
                chk("step_missing", cyc, exp_q.pop_front());
            end
            chk("held", int'(held), int'(m_lvl));
            chk("step_count", int'(step_count), int'(m_tally));
        end
    end

    task automatic drive(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        // reset with key pressed: outputs stay cleared throughout
        key_n = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_step", int'(step), 0);
            chk("rst_held", int'(held), 0);
            chk("rst_count", int'(step_count), 0);
        end
        reset = 1'b0;
        drive(1'b0, 12);
        drive(1'b1, 12);

        // clean press
        do_reset(2);
        drive(1'b0, 15);
        drive(1'b1, 15);
        chk("clean_count", int'(step_count), 1);
        chk("clean_held", int'(held), 0);

        // bounce shorter than the debounce window
        do_reset(2);
        drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 5);
        chk("bounce_count", int'(step_count), 0);

        // long hold
        do_reset(2);
        drive(1'b0, 50);
        drive(1'b1, 12);
`ifdef SCROLL_AUTO_REPEAT_EN
        chk("hold_count", int'(step_count), 5);
`else
        chk("hold_count", int'(step_count), 1);
`endif

        // release glitch while held
        do_reset(2);
        drive(1'b0, 30); drive(1'b1, 2); drive(1'b0, 30); drive(1'b1, 12);

        // random stimulus
        for (int i = 0; i < 150; i++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 45))
                                               : int'($urandom_range(1, 12));
            drive(1'($urandom_range(0, 1)), len);
        end
        drive(1'b1, 12);

        // tally wrap after 256 presses
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 8);
            drive(1'b1, 8);
        end
        chk("wrap_count", int'(step_count), 0);

        // reset during DEB_PRESS discards the pending press
        do_reset(2);
        drive(1'b0, 4);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        reset = 1'b0;
        drive(1'b1, 12);
        chk("rst_mid_count", int'(step_count), 0);
        chk("rst_mid_held", int'(held), 0);

        repeat (40) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
